// File: rtl/rv_alu_pipe.sv
// rv_alu_pipe: two-stage RV32I R-type execution core with a register file.
//   EX stage  : decodes an accepted instruction and latches operands (with forwarding).
//   OUT stage : holds the ALU result; the register file is written when a
//               result is captured here.
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   inst_valid/inst_ready/inst    instruction handshake and instruction word
//   load_en/load_addr/load_data   host register-file write port
//   res_valid/res_ready           result handshake
//   res_rd/res_data/res_err       destination index, result value, illegal flag
module rv_alu_pipe #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [31:0]     inst,
    input  logic            load_en,
    input  logic [4:0]      load_addr,
    input  logic [XLEN-1:0] load_data,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [4:0]      res_rd,
    output logic [XLEN-1:0] res_data,
    output logic            res_err
);

    localparam int SHW = $clog2(XLEN);
    localparam int AW  = $clog2(NREG);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    // Register index is architecturally present (indices >= NREG are illegal).
    function automatic logic idx_ok(input logic [4:0] idx);
        return ({1'b0, idx} < 6'(NREG));
    endfunction

    logic [XLEN-1:0] rf_q [NREG];

    logic            ex_valid_q, ex_valid_d;
    logic [4:0]      ex_rd_q, ex_rd_d;
    logic [3:0]      ex_op_q, ex_op_d;
    logic [XLEN-1:0] ex_a_q, ex_a_d;
    logic [XLEN-1:0] ex_b_q, ex_b_d;
    logic            ex_err_q, ex_err_d;

    logic            res_valid_q, res_valid_d;
    logic [4:0]      res_rd_q, res_rd_d;
    logic [XLEN-1:0] res_data_q, res_data_d;
    logic            res_err_q, res_err_d;

    logic            out_adv_s, ex_adv_s, accept_s, illegal_s;
    logic [6:0]      funct7_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0] opa_s, opb_s, alu_s, ex_res_s;
    logic [SHW-1:0]  shamt_s;

    assign funct7_s = inst[31:25];
    assign rs2_s    = inst[24:20];
    assign rs1_s    = inst[19:15];
    assign funct3_s = inst[14:12];
    assign rd_s     = inst[11:7];

    // Handshake: OUT drains when empty or consumed; EX moves only into a free OUT.
    always_comb begin
        out_adv_s  = !res_valid_q || res_ready;
        ex_adv_s   = ex_valid_q && out_adv_s;
        inst_ready = !ex_valid_q || out_adv_s;
        accept_s   = inst_valid && inst_ready;
    end

    // Illegal-instruction detection: only funct7=0100000 pairs with ADD->SUB and SRL->SRA.
    always_comb begin
        illegal_s = 1'b0;
        if (inst[6:0] != 7'b0110011) begin
            illegal_s = 1'b1;
        end else if (funct7_s != 7'b0000000 && funct7_s != 7'b0100000) begin
            illegal_s = 1'b1;
        end else if (funct7_s == 7'b0100000 && funct3_s != 3'b000 && funct3_s != 3'b101) begin
            illegal_s = 1'b1;
        end else if (!idx_ok(rs1_s) || !idx_ok(rs2_s) || !idx_ok(rd_s)) begin
            illegal_s = 1'b1;
        end else begin
            illegal_s = 1'b0;
        end
    end

    // Operand A: x0, then forward from EX (its write lands on this same edge), then host load, then RF.
    always_comb begin
        if (rs1_s == 5'd0) begin
            opa_s = '0;
        end else if (ex_valid_q && !ex_err_q && ex_rd_q == rs1_s) begin
            opa_s = ex_res_s;
        end else if (load_en && load_addr == rs1_s) begin
            opa_s = load_data;
        end else begin
            opa_s = rf_q[rs1_s[AW-1:0]];
        end
    end

    // Operand B: same priority as operand A.
    always_comb begin
        if (rs2_s == 5'd0) begin
            opb_s = '0;
        end else if (ex_valid_q && !ex_err_q && ex_rd_q == rs2_s) begin
            opb_s = ex_res_s;
        end else if (load_en && load_addr == rs2_s) begin
            opb_s = load_data;
        end else begin
            opb_s = rf_q[rs2_s[AW-1:0]];
        end
    end

    // ALU on the latched EX operands; illegal instructions produce zero.
    always_comb begin
        shamt_s = ex_b_q[SHW-1:0];
        alu_s   = '0;
        case (ex_op_q)
            OP_ADD:  alu_s = ex_a_q + ex_b_q;
            OP_SUB:  alu_s = ex_a_q - ex_b_q;
            OP_SLL:  alu_s = ex_a_q << shamt_s;
            OP_SLT:  alu_s[0] = ($signed(ex_a_q) < $signed(ex_b_q));
            OP_SLTU: alu_s[0] = (ex_a_q < ex_b_q);
            OP_XOR:  alu_s = ex_a_q ^ ex_b_q;
            OP_SRL:  alu_s = ex_a_q >> shamt_s;
            OP_SRA:  alu_s = $unsigned($signed(ex_a_q) >>> shamt_s);
            OP_OR:   alu_s = ex_a_q | ex_b_q;
            OP_AND:  alu_s = ex_a_q & ex_b_q;
            default: alu_s = '0;
        endcase
        if (ex_err_q) begin
            ex_res_s = '0;
        end else begin
            ex_res_s = alu_s;
        end
    end

    // EX next state: capture on accept, empty when drained, otherwise hold.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rd_d    = ex_rd_q;
        ex_op_d    = ex_op_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_err_d   = ex_err_q;
        if (accept_s) begin
            ex_valid_d = 1'b1;
            ex_rd_d    = rd_s;
            ex_op_d    = {funct7_s[5], funct3_s};
            ex_a_d     = opa_s;
            ex_b_d     = opb_s;
            ex_err_d   = illegal_s;
        end else if (ex_adv_s) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // OUT next state: load from EX when it advances, drop valid when drained with nothing behind.
    always_comb begin
        res_valid_d = res_valid_q;
        res_rd_d    = res_rd_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        if (ex_adv_s) begin
            res_valid_d = 1'b1;
            res_rd_d    = ex_rd_q;
            res_data_d  = ex_res_s;
            res_err_d   = ex_err_q;
        end else if (out_adv_s) begin
            res_valid_d = 1'b0;
        end else begin
            res_valid_d = res_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_op_q     <= 4'd0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_err_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_rd_q    <= 5'd0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            ex_op_q     <= ex_op_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_err_q    <= ex_err_d;
            res_valid_q <= res_valid_d;
            res_rd_q    <= res_rd_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    // Register file: host load first, writeback second so writeback wins a same-index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (load_en && load_addr != 5'd0 && idx_ok(load_addr)) begin
                rf_q[load_addr[AW-1:0]] <= load_data;
            end
            if (ex_adv_s && !ex_err_q && ex_rd_q != 5'd0) begin
                rf_q[ex_rd_q[AW-1:0]] <= ex_res_s;
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_rd    = res_rd_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_rv_alu_pipe.sv
// Directed bench for rv_alu_pipe (XLEN=32, NREG=16).
module tb_rv_alu_pipe;

    logic        clk;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [31:0] load_data;
    logic        res_valid;
    logic        res_ready;
    logic [4:0]  res_rd;
    logic [31:0] res_data;
    logic        res_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] ins;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vq[$];

    rv_alu_pipe #(.XLEN(32), .NREG(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_rd     (res_rd),
        .res_data   (res_data),
        .res_err    (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic add_vec(input logic [31:0] ins, input logic [4:0] rd,
                           input logic [31:0] data, input logic err);
        vec_t v;
        v.ins = ins; v.rd = rd; v.data = data; v.err = err;
        vq.push_back(v);
    endtask

    task automatic load_reg(input logic [4:0] a, input logic [31:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    // Issue queued vectors back to back; each result must appear one cycle after its successor issues.
    task automatic run_stream(input string name);
        int n;
        n = vq.size();
        res_ready = 1'b1;
        for (int i = 0; i <= n; i++) begin
            if (i < n) begin
                inst_valid = 1'b1;
                inst = vq[i].ins;
                check_eq($sformatf("%s_rdy%0d", name, i), 64'(inst_ready), 64'd1);
            end else begin
                inst_valid = 1'b0;
            end
            tick();
            if (i == 0) begin
                check_eq($sformatf("%s_lat", name), 64'(res_valid), 64'd0);
            end else begin
                check_eq($sformatf("%s_v%0d", name, i-1), 64'(res_valid), 64'd1);
                check_eq($sformatf("%s_rd%0d", name, i-1), 64'(res_rd), 64'(vq[i-1].rd));
                check_eq($sformatf("%s_d%0d", name, i-1), 64'(res_data), 64'(vq[i-1].data));
                check_eq($sformatf("%s_e%0d", name, i-1), 64'(res_err), 64'(vq[i-1].err));
            end
        end
        vq.delete();
        tick();
        check_eq($sformatf("%s_drain", name), 64'(res_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1; inst_valid = 1'b0; inst = 32'd0; load_en = 1'b0;
        load_addr = 5'd0; load_data = 32'd0; res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_valid", 64'(res_valid), 64'd0);
        check_eq("rst_data", 64'(res_data), 64'd0);
        check_eq("rst_rd", 64'(res_rd), 64'd0);
        check_eq("rst_err", 64'(res_err), 64'd0);
        check_eq("rst_ready", 64'(inst_ready), 64'd1);

        // Group A: x1=5, x2=7
        load_reg(5'd1, 32'd5);
        load_reg(5'd2, 32'd7);
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),  5'd3,  32'd12, 1'b0);          // ADD
        add_vec(rtype(7'h00, 5'd3, 5'd3, 3'b000, 5'd5),  5'd5,  32'd24, 1'b0);          // RAW ADD
        add_vec(rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd4),  5'd4,  32'hFFFFFFFE, 1'b0);    // SUB
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd6),  5'd6,  32'd2, 1'b0);           // XOR
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd7),  5'd7,  32'd7, 1'b0);           // OR
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd8),  5'd8,  32'd5, 1'b0);           // AND
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b001, 5'd9),  5'd9,  32'h280, 1'b0);         // SLL
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd0),  5'd0,  32'd12, 1'b0);          // ADD x0
        add_vec(rtype(7'h00, 5'd1, 5'd0, 3'b000, 5'd10), 5'd10, 32'd5, 1'b0);           // x0 reads 0
        add_vec({7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0010011}, 5'd3, 32'd0, 1'b1);      // bad opcode
        add_vec(rtype(7'h00, 5'd0, 5'd3, 3'b000, 5'd11), 5'd11, 32'd12, 1'b0);          // x3 untouched
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd20), 5'd20, 32'd0, 1'b1);           // rd >= NREG
        add_vec(rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd6),  5'd6,  32'd0, 1'b1);           // bad funct7
        add_vec(rtype(7'h20, 5'd2, 5'd1, 3'b001, 5'd6),  5'd6,  32'd0, 1'b1);           // bad pair
        add_vec(rtype(7'h00, 5'd0, 5'd6, 3'b000, 5'd12), 5'd12, 32'd2, 1'b0);           // x6 untouched
        run_stream("A");

        // Group B: signed/unsigned compares and shifts
        load_reg(5'd1, 32'hFFFFFFFF);
        load_reg(5'd2, 32'd1);
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd12), 5'd12, 32'd1, 1'b0);           // SLT
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b011, 5'd13), 5'd13, 32'd0, 1'b0);           // SLTU
        add_vec(rtype(7'h20, 5'd2, 5'd1, 3'b101, 5'd14), 5'd14, 32'hFFFFFFFF, 1'b0);    // SRA
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b101, 5'd15), 5'd15, 32'h7FFFFFFF, 1'b0);    // SRL
        add_vec(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd6),  5'd6,  32'd0, 1'b0);           // wrap
        run_stream("B");

        // Backpressure: two in flight, three stalled cycles
        res_ready = 1'b0;
        inst_valid = 1'b1;
        inst = rtype(7'h00, 5'd2, 5'd2, 3'b000, 5'd7);                                  // 2
        tick();
        check_eq("bp_rdy1", 64'(inst_ready), 64'd1);
        inst = rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd8);                                  // FFFFFFFE
        tick();
        inst = rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd9);                                  // must not be taken
        check_eq("bp_rdy0", 64'(inst_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq($sformatf("bp_v%0d", c), 64'(res_valid), 64'd1);
            check_eq($sformatf("bp_rd%0d", c), 64'(res_rd), 64'd7);
            check_eq($sformatf("bp_d%0d", c), 64'(res_data), 64'd2);
            check_eq($sformatf("bp_rdy%0d", c), 64'(inst_ready), 64'd0);
        end
        inst_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        check_eq("bp_v2nd", 64'(res_valid), 64'd1);
        check_eq("bp_rd2nd", 64'(res_rd), 64'd8);
        check_eq("bp_d2nd", 64'(res_data), 64'hFFFFFFFE);
        tick();
        check_eq("bp_empty", 64'(res_valid), 64'd0);

        // Reset mid-stream: OUT and EX both occupied
        res_ready = 1'b0;
        inst_valid = 1'b1;
        inst = rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        tick();
        inst = rtype(7'h00, 5'd2, 5'd2, 3'b000, 5'd4);
        tick();
        inst_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mrst_valid", 64'(res_valid), 64'd0);
        check_eq("mrst_data", 64'(res_data), 64'd0);
        check_eq("mrst_ready", 64'(inst_ready), 64'd1);
        add_vec(rtype(7'h00, 5'd1, 5'd4, 3'b000, 5'd5), 5'd5, 32'd0, 1'b0);
        add_vec(rtype(7'h00, 5'd2, 5'd2, 3'b000, 5'd6), 5'd6, 32'd0, 1'b0);
        run_stream("R");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
